// File: rtl/mdu_iterative_core_if.sv
// EX-stage to multiply/divide unit request and read-back bundle.
interface mdu_iterative_core_if;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [2:0]  operation;
  logic        start;
  logic        busy;
  logic [31:0] dataRead;

  modport master (
    output operand1, operand2, operation, start,
    input  busy, dataRead
  );

  modport slave (
    input  operand1, operand2, operation, start,
    output busy, dataRead
  );
endinterface

// File: rtl/mdu_iterative_core.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
// Multiply latency is programmable; division is 32-step restoring plus a sign fix cycle.
module mdu_iterative_core #(
  parameter int unsigned MUL_LATENCY = 5,
  parameter int unsigned DIV_ITERS   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  mdu_iterative_core_if.slave  bus
);

  localparam int unsigned W  = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned CW = 6;

  localparam logic [2:0] OP_READ_HI  = 3'd0;
  localparam logic [2:0] OP_READ_LO  = 3'd1;
  localparam logic [2:0] OP_WRITE_HI = 3'd2;
  localparam logic [2:0] OP_WRITE_LO = 3'd3;
  localparam logic [2:0] OP_MULT     = 3'd4;
  localparam logic [2:0] OP_MULTU    = 3'd5;
  localparam logic [2:0] OP_DIV      = 3'd6;
  localparam logic [2:0] OP_DIVU     = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_ITER = 2'd2,
    S_DIV_FIX  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;
  logic [CW-1:0]  r_cnt;
  logic [PW-1:0]  r_prod;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_quo;
  logic [W-1:0]   r_dvs;
  logic [W-1:0]   r_dividend;
  logic           r_q_neg;
  logic           r_r_neg;
  logic           r_dvz;

  logic           w_accept;
  logic           w_busy;
  logic [W-1:0]   w_data_read;
  logic           w_mul_signed;
  logic           w_div_signed;
  logic [PW-1:0]  w_a64;
  logic [PW-1:0]  w_b64;
  logic [PW-1:0]  w_prod;
  logic [W-1:0]   w_a_abs;
  logic [W-1:0]   w_b_abs;
  logic [W:0]     w_shift;
  logic           w_ge;
  logic [W-1:0]   w_rem_nxt;
  logic [W-1:0]   w_q_fix;
  logic [W-1:0]   w_r_fix;

  assign w_accept = bus.start && (r_state == S_IDLE);

  // Operand conditioning for both datapaths, sampled only on accept.
  assign w_mul_signed = (bus.operation == OP_MULT);
  assign w_div_signed = (bus.operation == OP_DIV);
  assign w_a64  = {{W{w_mul_signed & bus.operand1[W-1]}}, bus.operand1};
  assign w_b64  = {{W{w_mul_signed & bus.operand2[W-1]}}, bus.operand2};
  assign w_prod = w_a64 * w_b64;
  assign w_a_abs = (w_div_signed && bus.operand1[W-1]) ? W'(~bus.operand1 + W'(1)) : bus.operand1;
  assign w_b_abs = (w_div_signed && bus.operand2[W-1]) ? W'(~bus.operand2 + W'(1)) : bus.operand2;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_shift   = {r_rem, r_quo[W-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? W'(w_shift - {1'b0, r_dvs}) : W'(w_shift);

  assign w_q_fix = r_q_neg ? W'(~r_quo + W'(1)) : r_quo;
  assign w_r_fix = r_r_neg ? W'(~r_rem + W'(1)) : r_rem;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.operation == OP_MULT || bus.operation == OP_MULTU) w_next = S_MUL_WAIT;
          else if (bus.operation == OP_DIV || bus.operation == OP_DIVU) w_next = S_DIV_ITER;
        end
      end
      S_MUL_WAIT: if (r_cnt == CW'(1)) w_next = S_IDLE;
      S_DIV_ITER: if (r_cnt == CW'(1)) w_next = S_DIV_FIX;
      S_DIV_FIX:  w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_busy = 1'b0;
    if (r_state != S_IDLE) w_busy = 1'b1;
  end

  assign bus.busy = w_busy;

  // HI/LO read port is combinational so EX can forward in the same cycle.
  always_comb begin
    w_data_read = '0;
    if (bus.operation == OP_READ_HI)      w_data_read = r_hi;
    else if (bus.operation == OP_READ_LO) w_data_read = r_lo;
  end

  assign bus.dataRead = w_data_read;

  // Datapath and HI/LO updates.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_prod     <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_dividend <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_dvz      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            unique case (bus.operation)
              OP_WRITE_HI: r_hi <= bus.operand1;
              OP_WRITE_LO: r_lo <= bus.operand1;
              OP_MULT, OP_MULTU: begin
                r_prod <= w_prod;
                r_cnt  <= CW'(MUL_LATENCY);
              end
              OP_DIV, OP_DIVU: begin
                r_rem      <= '0;
                r_quo      <= w_a_abs;
                r_dvs      <= w_b_abs;
                r_dividend <= bus.operand1;
                r_dvz      <= (bus.operand2 == '0);
                r_q_neg    <= w_div_signed & (bus.operand1[W-1] ^ bus.operand2[W-1]);
                r_r_neg    <= w_div_signed & bus.operand1[W-1];
                r_cnt      <= CW'(DIV_ITERS);
              end
              OP_READ_HI, OP_READ_LO: ;
              default: ;
            endcase
          end
        end
        S_MUL_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) {r_hi, r_lo} <= r_prod;
        end
        S_DIV_ITER: begin
          r_cnt <= r_cnt - CW'(1);
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[W-2:0], w_ge};
        end
        S_DIV_FIX: begin
          // Divide by zero returns all-ones quotient and the raw dividend.
          if (r_dvz) begin
            r_lo <= '1;
            r_hi <= r_dividend;
          end else begin
            r_lo <= w_q_fix;
            r_hi <= w_r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
